// File: rtl/pic_ctrl_pkg.sv
// Shared definitions for the PIC command path: frame-controller state encoding,
// framing constants and the opcodes understood by the downstream register logic.
package pic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_OP   = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_DH   = 3'd3,
    ST_GET_DL   = 3'd4,
    ST_GET_CHK  = 3'd5,
    ST_HOLD     = 3'd6
  } cmd_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
  localparam int         FRAME_LEN         = 6;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_WRITE_REG = 8'h01;
  localparam logic [7:0] OP_SET_BITS  = 8'h02;
  localparam logic [7:0] OP_CLR_BITS  = 8'h03;

  function automatic logic is_collecting(input cmd_state_e s);
    return (s == ST_GET_OP) || (s == ST_GET_ADDR) || (s == ST_GET_DH) ||
           (s == ST_GET_DL) || (s == ST_GET_CHK);
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Saturating idle-gap counter between received bytes; raises a registered
// expiry flag on the cycle that completes TIMEOUT_CYCLES idle cycles.
module uart_gap_timer #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] PRE   = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  // The flag is registered one cycle ahead, so it is high exactly during the
  // idle cycle in which the count reaches TIMEOUT_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CW'(1);
    end
    expired_d = en && !clr && (cnt_d == PRE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller: hunts for SYNC, collects OP/ADDR/DATA_H/DATA_L/CHK,
// checks the 8-bit sum and hands one write command out on a valid/ready handshake.
module uart_cmd_ctrl
  import pic_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_op,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_checksum,
  output logic        err_timeout,
  output logic        err_overrun,
  output logic [7:0]  frame_ok_cnt
);

  cmd_state_e state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] op_q, op_d, addr_q, addr_d, dh_q, dh_d, dl_q, dl_d;
  logic [7:0] ok_cnt_q, ok_cnt_d;
  logic       valid_q, valid_d;
  logic       err_chk_q, err_chk_d, err_to_q, err_to_d, err_ovr_q, err_ovr_d;
  logic       collecting;
  logic       expired;

  assign collecting = is_collecting(state_q);

  uart_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (rx_valid),
    .en     (collecting),
    .expired(expired)
  );

  // A byte arriving on the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    addr_d    = addr_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    ok_cnt_d  = ok_cnt_q;
    valid_d   = valid_q;
    err_chk_d = 1'b0;
    err_to_d  = 1'b0;
    err_ovr_d = 1'b0;

    if (collecting && !rx_valid && expired) begin
      state_d  = ST_IDLE;
      err_to_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_valid && (rx_byte == SYNC_BYTE)) begin
            state_d = ST_GET_OP;
            acc_d   = '0;
          end
        end
        ST_GET_OP: begin
          if (rx_valid) begin
            op_d    = rx_byte;
            acc_d   = acc_q + rx_byte;
            state_d = ST_GET_ADDR;
          end
        end
        ST_GET_ADDR: begin
          if (rx_valid) begin
            addr_d  = rx_byte;
            acc_d   = acc_q + rx_byte;
            state_d = ST_GET_DH;
          end
        end
        ST_GET_DH: begin
          if (rx_valid) begin
            dh_d    = rx_byte;
            acc_d   = acc_q + rx_byte;
            state_d = ST_GET_DL;
          end
        end
        ST_GET_DL: begin
          if (rx_valid) begin
            dl_d    = rx_byte;
            acc_d   = acc_q + rx_byte;
            state_d = ST_GET_CHK;
          end
        end
        ST_GET_CHK: begin
          if (rx_valid) begin
            if (rx_byte == acc_q) begin
              state_d  = ST_HOLD;
              valid_d  = 1'b1;
              ok_cnt_d = ok_cnt_q + 8'd1;
            end else begin
              state_d   = ST_IDLE;
              err_chk_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          // On the handshake cycle an incoming byte is judged as if already idle.
          if (cmd_ready) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
            if (rx_valid && (rx_byte == SYNC_BYTE)) begin
              state_d = ST_GET_OP;
              acc_d   = '0;
            end
          end else if (rx_valid) begin
            err_ovr_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      dh_q      <= '0;
      dl_q      <= '0;
      ok_cnt_q  <= '0;
      valid_q   <= 1'b0;
      err_chk_q <= 1'b0;
      err_to_q  <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      dh_q      <= dh_d;
      dl_q      <= dl_d;
      ok_cnt_q  <= ok_cnt_d;
      valid_q   <= valid_d;
      err_chk_q <= err_chk_d;
      err_to_q  <= err_to_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  assign cmd_valid    = valid_q;
  assign cmd_op       = op_q;
  assign cmd_addr     = addr_q;
  assign cmd_data     = {dh_q, dl_q};
  assign err_checksum = err_chk_q;
  assign err_timeout  = err_to_q;
  assign err_overrun  = err_ovr_q;
  assign frame_ok_cnt = ok_cnt_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed scenarios plus a randomized
// byte stream checked against a frame-level reference parser.
module tb_uart_cmd_ctrl;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_checksum;
  logic        err_timeout;
  logic        err_overrun;
  logic [7:0]  frame_ok_cnt;

  int testCount = 0;
  int failCount = 0;
  int expOk     = 0;

  int nChk = 0, nTo = 0, nOvr = 0, nValid = 0;
  logic [31:0] gotQ[$];

  uart_cmd_ctrl #(
    .SYNC_BYTE     (8'hAA),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .err_checksum(err_checksum),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .frame_ok_cnt(frame_ok_cnt)
  );

  always #5 clk = ~clk;

  // Passive observer: tallies pulses and records every accepted command.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_checksum) nChk++;
      if (err_timeout) nTo++;
      if (err_overrun) nOvr++;
      if (cmd_valid) nValid++;
      if (cmd_valid && cmd_ready) gotQ.push_back({cmd_op, cmd_addr, cmd_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    testCount++; if (cmd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b want 0", cmd_valid); end
    testCount++; if ({cmd_op, cmd_addr, cmd_data} !== 32'h0) begin failCount++; $display("[TB] FAIL reset_fields: got %h want 0", {cmd_op, cmd_addr, cmd_data}); end
    testCount++; if ({err_checksum, err_timeout, err_overrun} !== 3'b000) begin failCount++; $display("[TB] FAIL reset_errs: got %b want 000", {err_checksum, err_timeout, err_overrun}); end
    testCount++; if (frame_ok_cnt !== 8'd0) begin failCount++; $display("[TB] FAIL reset_cnt: got %0d want 0", frame_ok_cnt); end
    expOk = 0;
  endtask

  task automatic test_good_frame();
    int v0, e0;
    cmd_ready = 1'b1;
    v0 = nValid; e0 = nChk + nTo + nOvr;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34);
    testCount++; if (cmd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL good_early: got %b want 0", cmd_valid); end
    send_byte(8'h57);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1) begin failCount++; $display("[TB] FAIL good_valid: got %b want 1", cmd_valid); end
    testCount++; if ({cmd_op, cmd_addr, cmd_data} !== 32'h0110_1234) begin failCount++; $display("[TB] FAIL good_fields: got %h want 01101234", {cmd_op, cmd_addr, cmd_data}); end
    testCount++; if (frame_ok_cnt !== 8'(expOk)) begin failCount++; $display("[TB] FAIL good_cnt: got %0d want %0d", frame_ok_cnt, expOk); end
    step();
    testCount++; if (cmd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL good_drop: got %b want 0", cmd_valid); end
    testCount++; if (nValid - v0 !== 1) begin failCount++; $display("[TB] FAIL good_cycles: got %0d want 1", nValid - v0); end
    testCount++; if (nChk + nTo + nOvr - e0 !== 0) begin failCount++; $display("[TB] FAIL good_noerr: got %0d want 0", nChk + nTo + nOvr - e0); end
  endtask

  task automatic test_bad_checksum();
    int c0, v0;
    cmd_ready = 1'b1;
    c0 = nChk; v0 = nValid;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h58);
    testCount++; if (err_checksum !== 1'b1) begin failCount++; $display("[TB] FAIL bad_pulse: got %b want 1", err_checksum); end
    step();
    testCount++; if (err_checksum !== 1'b0) begin failCount++; $display("[TB] FAIL bad_width: got %b want 0", err_checksum); end
    testCount++; if (nValid - v0 !== 0 || nChk - c0 !== 1) begin failCount++; $display("[TB] FAIL bad_counts: got valid=%0d chk=%0d want 0/1", nValid - v0, nChk - c0); end
    testCount++; if (frame_ok_cnt !== 8'(expOk)) begin failCount++; $display("[TB] FAIL bad_cnt: got %0d want %0d", frame_ok_cnt, expOk); end
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h40); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h42);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 32'h0340_00FF) begin failCount++; $display("[TB] FAIL bad_next: got v=%b %h want 1 034000FF", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
    step();
  endtask

  task automatic test_timeout();
    int k, t0;
    cmd_ready = 1'b1;
    t0 = nTo;
    send_byte(8'hAA); send_byte(8'h01);
    k = 1;
    while (err_timeout !== 1'b1 && k < 3 * TMO) begin step(); k++; end
    testCount++; if (k !== TMO + 1) begin failCount++; $display("[TB] FAIL timeout_delay: got %0d want %0d", k, TMO + 1); end
    step();
    testCount++; if (err_timeout !== 1'b0 || nTo - t0 !== 1) begin failCount++; $display("[TB] FAIL timeout_width: got pulse=%b count=%0d want 0/1", err_timeout, nTo - t0); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h57);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 32'h0110_1234) begin failCount++; $display("[TB] FAIL timeout_next: got v=%b %h want 1 01101234", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
    step();
    t0 = nTo;
    send_byte(8'hAA); send_byte(8'h01);
    repeat (TMO - 1) step();
    send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h57);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1 || nTo - t0 !== 0) begin failCount++; $display("[TB] FAIL timeout_edge: got v=%b timeouts=%0d want 1/0", cmd_valid, nTo - t0); end
    testCount++; if (frame_ok_cnt !== 8'(expOk)) begin failCount++; $display("[TB] FAIL timeout_cnt: got %0d want %0d", frame_ok_cnt, expOk); end
    step();
  endtask

  task automatic test_backpressure();
    int bad;
    cmd_ready = 1'b0;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h20); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h9A);
    expOk++;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      testCount++;
      if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 32'h0220_ABCD) begin
        failCount++; bad++;
        if (bad < 4) $display("[TB] FAIL hold_stable: got v=%b %h want 1 0220ABCD", cmd_valid, {cmd_op, cmd_addr, cmd_data});
      end
      step();
    end
    send_byte(8'h55);
    testCount++; if (err_overrun !== 1'b1) begin failCount++; $display("[TB] FAIL overrun_pulse: got %b want 1", err_overrun); end
    testCount++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 32'h0220_ABCD) begin failCount++; $display("[TB] FAIL overrun_keep: got v=%b %h want 1 0220ABCD", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
    step();
    testCount++; if (err_overrun !== 1'b0) begin failCount++; $display("[TB] FAIL overrun_width: got %b want 0", err_overrun); end
    cmd_ready = 1'b1;
    step();
    testCount++; if (cmd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL release_drop: got %b want 0", cmd_valid); end
    testCount++; if (frame_ok_cnt !== 8'(expOk)) begin failCount++; $display("[TB] FAIL release_cnt: got %0d want %0d", frame_ok_cnt, expOk); end
  endtask

  task automatic test_resync();
    int o0;
    cmd_ready = 1'b1;
    o0 = nOvr;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00); send_byte(8'h54);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 32'hAAAA_0000) begin failCount++; $display("[TB] FAIL resync_fields: got v=%b %h want 1 AAAA0000", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
    step();
    cmd_ready = 1'b0;
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h01); send_byte(8'h00); send_byte(8'h0F); send_byte(8'h13);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1) begin failCount++; $display("[TB] FAIL hs_hold: got %b want 1", cmd_valid); end
    cmd_ready = 1'b1;
    send_byte(8'hAA);
    testCount++; if (cmd_valid !== 1'b0 || err_overrun !== 1'b0) begin failCount++; $display("[TB] FAIL hs_sync: got v=%b ovr=%b want 0/0", cmd_valid, err_overrun); end
    send_byte(8'h01); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h57);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 32'h0110_1234) begin failCount++; $display("[TB] FAIL hs_frame: got v=%b %h want 1 01101234", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
    testCount++; if (nOvr - o0 !== 0 || frame_ok_cnt !== 8'(expOk)) begin failCount++; $display("[TB] FAIL hs_counts: got ovr=%0d cnt=%0d want 0/%0d", nOvr - o0, frame_ok_cnt, expOk); end
    step();
  endtask

  task automatic test_reset_midframe();
    int e0;
    cmd_ready = 1'b1;
    e0 = nChk + nTo + nOvr;
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    expOk = 0;
    testCount++; if (frame_ok_cnt !== 8'd0 || cmd_valid !== 1'b0 || {cmd_op, cmd_addr} !== 16'h0) begin failCount++; $display("[TB] FAIL midrst_clear: got cnt=%0d v=%b %h want 0", frame_ok_cnt, cmd_valid, {cmd_op, cmd_addr}); end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10); send_byte(8'h12); send_byte(8'h34); send_byte(8'h57);
    expOk++;
    testCount++; if (cmd_valid !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== 32'h0110_1234) begin failCount++; $display("[TB] FAIL midrst_frame: got v=%b %h want 1 01101234", cmd_valid, {cmd_op, cmd_addr, cmd_data}); end
    testCount++; if (frame_ok_cnt !== 8'd1) begin failCount++; $display("[TB] FAIL midrst_cnt: got %0d want 1", frame_ok_cnt); end
    step();
    testCount++; if (nChk + nTo + nOvr - e0 !== 0) begin failCount++; $display("[TB] FAIL midrst_noerr: got %0d want 0", nChk + nTo + nOvr - e0); end
  endtask

  task automatic test_random();
    logic [7:0]  stream[$];
    logic [31:0] expQ[$];
    int          expBad, c0, t0, o0, bad;
    logic [7:0]  f[4];
    logic [8:0]  s;
    stream.delete(); expQ.delete(); gotQ.delete();
    expBad = 0;
    for (int n = 0; n < 300; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        logic [7:0] junk;
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hAA) junk = 8'h5A;
        stream.push_back(junk);
      end
      stream.push_back(8'hAA);
      s = '0;
      for (int j = 0; j < 4; j++) begin
        f[j] = 8'($urandom_range(0, 255));
        stream.push_back(f[j]);
        s = 9'((s + f[j]) % 256);
      end
      if ($urandom_range(0, 3) == 0) stream.push_back(8'((s + $urandom_range(1, 255)) % 256));
      else stream.push_back(s[7:0]);
    end
    // Reference: scan for SYNC, take the next five bytes as a frame, judge its sum.
    for (int i = 0; i < stream.size(); ) begin
      if (stream[i] != 8'hAA || i + 5 >= stream.size()) begin
        i++;
      end else begin
        int sum;
        sum = (int'(stream[i+1]) + int'(stream[i+2]) + int'(stream[i+3]) + int'(stream[i+4])) % 256;
        if (sum == int'(stream[i+5])) expQ.push_back({stream[i+1], stream[i+2], stream[i+3], stream[i+4]});
        else expBad++;
        i += 6;
      end
    end
    cmd_ready = 1'b1;
    c0 = nChk; t0 = nTo; o0 = nOvr;
    foreach (stream[i]) begin
      send_byte(stream[i]);
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (3) step();
    expOk = (expOk + expQ.size()) % 256;
    testCount++; if (gotQ.size() !== expQ.size()) begin failCount++; $display("[TB] FAIL rand_ncmd: got %0d want %0d", gotQ.size(), expQ.size()); end
    bad = 0;
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      testCount++;
      if (gotQ[i] !== expQ[i]) begin
        failCount++; bad++;
        if (bad < 4) $display("[TB] FAIL rand_cmd[%0d]: got %h want %h", i, gotQ[i], expQ[i]);
      end
    end
    testCount++; if (nChk - c0 !== expBad) begin failCount++; $display("[TB] FAIL rand_chkerr: got %0d want %0d", nChk - c0, expBad); end
    testCount++; if (nTo - t0 !== 0 || nOvr - o0 !== 0) begin failCount++; $display("[TB] FAIL rand_othererr: got to=%0d ovr=%0d want 0/0", nTo - t0, nOvr - o0); end
    testCount++; if (frame_ok_cnt !== 8'(expOk)) begin failCount++; $display("[TB] FAIL rand_cnt: got %0d want %0d", frame_ok_cnt, expOk); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_backpressure();
    test_resync();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
